// File: rtl/reg_wb_ctrl_pkg.sv
// Shared CPU constants and types for the register writeback path.
// Also carries the zero-register test used by both the queue and the forward match.
package reg_wb_ctrl_pkg;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;
   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [REG_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // Writes to the zero register are architecturally dead.
   function automatic logic idx_live(input logic [REG_W-1:0] idx);
      return idx != ZERO_REG;
   endfunction
endpackage

// File: rtl/wb_fwd_match.sv
// Hazard compare-and-select for one read port over the queued writebacks.
// Entries arrive ordered oldest first, so the last match scanned is the youngest.
module wb_fwd_match
   import reg_wb_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic [REG_W-1:0]        rd_idx_i,
   input  wb_entry_t [DEPTH-1:0]   ent_i,
   input  logic [DEPTH-1:0]        ent_vld_i,
   output logic                    hit_o,
   output logic [DATA_W-1:0]       fwd_o
);

   // Scan oldest to youngest; later matches override earlier ones.
   always_comb begin
      hit_o = 1'b0;
      fwd_o = {DATA_W{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
         hit_o = hit_o | (ent_vld_i[k] & idx_live(rd_idx_i) & (ent_i[k].idx == rd_idx_i));
         fwd_o = (ent_vld_i[k] && idx_live(rd_idx_i) && (ent_i[k].idx == rd_idx_i))
                 ? ent_i[k].data : fwd_o;
      end
   end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Writeback queue merging ALU and load results into one register-file write per cycle.
// Also snoops two read ports and forwards the youngest pending value.
module reg_wb_ctrl
   import reg_wb_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [REG_W-1:0]  alu_wr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [REG_W-1:0]  mem_wr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic              RegWrite,
   output logic [REG_W-1:0]  WR,
   output logic [DATA_W-1:0] data,
   input  logic [REG_W-1:0]  Read_A,
   input  logic [REG_W-1:0]  Read_B,
   output logic              hit_A,
   output logic              hit_B,
   output logic [DATA_W-1:0] fwd_A,
   output logic [DATA_W-1:0] fwd_B
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] DEPTH_M2_C = CW'(DEPTH - 2);

   wb_entry_t          ent_q [DEPTH];
   logic [PW-1:0]      head_q, head_d;
   logic [PW-1:0]      tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;
   logic               mem_push_s, alu_push_s, pop_s;
   logic [PW-1:0]      alu_slot_s;
   wb_entry_t [DEPTH-1:0] ord_s;
   logic [DEPTH-1:0]   ord_vld_s;
   wb_entry_t          head_ent_s;

   // ALU needs room for two so a same-cycle load can never be starved of a slot.
   assign mem_ready = (count_q < DEPTH_C);
   assign alu_ready = (count_q <= DEPTH_M2_C);

   // Next-state for pointers and occupancy; the load is enqueued ahead of the ALU.
   always_comb begin
      mem_push_s = mem_valid & mem_ready & idx_live(mem_wr);
      alu_push_s = alu_valid & alu_ready & idx_live(alu_wr);
      pop_s      = (count_q != {CW{1'b0}});
      alu_slot_s = mem_push_s ? (tail_q + PW'(1)) : tail_q;
      tail_d     = tail_q + PW'(mem_push_s) + PW'(alu_push_s);
      head_d     = head_q + PW'(pop_s);
      count_d    = count_q + CW'(mem_push_s) + CW'(alu_push_s) - CW'(pop_s);
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= {PW{1'b0}};
         tail_q  <= {PW{1'b0}};
         count_q <= {CW{1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are only ever observed through count-qualified views.
   always_ff @(posedge clk) begin
      if (!rst && mem_push_s) begin
         ent_q[tail_q] <= '{idx: mem_wr, data: mem_data};
      end
      if (!rst && alu_push_s) begin
         ent_q[alu_slot_s] <= '{idx: alu_wr, data: alu_data};
      end
   end

   // Oldest-first view of the queue with per-slot valid flags.
   always_comb begin
      head_ent_s = ent_q[head_q];
      for (int k = 0; k < DEPTH; k++) begin
         ord_s[k]     = ent_q[head_q + PW'(k)];
         ord_vld_s[k] = (CW'(k) < count_q);
      end
   end

   assign RegWrite = pop_s;
   assign WR       = pop_s ? head_ent_s.idx  : ZERO_REG;
   assign data     = pop_s ? head_ent_s.data : {DATA_W{1'b0}};

   wb_fwd_match #(.DEPTH(DEPTH)) u_match_a (
      .rd_idx_i  (Read_A),
      .ent_i     (ord_s),
      .ent_vld_i (ord_vld_s),
      .hit_o     (hit_A),
      .fwd_o     (fwd_A)
   );

   wb_fwd_match #(.DEPTH(DEPTH)) u_match_b (
      .rd_idx_i  (Read_B),
      .ent_i     (ord_s),
      .ent_vld_i (ord_vld_s),
      .hit_o     (hit_B),
      .fwd_o     (fwd_B)
   );

endmodule
